// File: rtl/zrb_sd_pkg.sv
// rtl/zrb_sd_pkg.sv - shared encodings and constants for the SD SPI-mode command path
package zrb_sd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PRE  = 2'd1,
        ST_SEND = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [5:0] CMD0   = 6'd0;
    localparam logic [5:0] CMD8   = 6'd8;
    localparam logic [5:0] CMD17  = 6'd17;
    localparam logic [5:0] CMD55  = 6'd55;
    localparam logic [5:0] ACMD41 = 6'd41;
    localparam logic [5:0] CMD58  = 6'd58;

    localparam logic [6:0] CRC7_POLY = 7'h09;

    localparam logic [7:0] CRC_BYTE_CMD0 = 8'h95;
    localparam logic [7:0] CRC_BYTE_CMD8 = 8'h87;
    localparam logic [7:0] CRC_BYTE_NONE = 8'hFF;

    // Only CMD0 and CMD8 are CRC-checked by a card in SPI mode; everything else gets a dummy.
    function automatic logic [7:0] fixed_crc_byte(input logic [5:0] idx);
        if (idx == CMD0)
            return CRC_BYTE_CMD0;
        else if (idx == CMD8)
            return CRC_BYTE_CMD8;
        else
            return CRC_BYTE_NONE;
    endfunction

endpackage

// File: rtl/zrb_crc7_byte.sv
// rtl/zrb_crc7_byte.sv - combinational CRC7 (x^7+x^3+1) update over one byte, MSB first
module zrb_crc7_byte
    import zrb_sd_pkg::*;
(
    input  logic [6:0] crc_in,
    input  logic [7:0] data,
    output logic [6:0] crc_out
);

    logic [6:0] c;

    always_comb begin
        c = crc_in;
        for (int i = 7; i >= 0; i--) begin
            if (c[6] ^ data[i])
                c = {c[5:0], 1'b0} ^ CRC7_POLY;
            else
                c = {c[5:0], 1'b0};
        end
        crc_out = c;
    end

endmodule

// File: rtl/zrb_sd_cmd_framer.sv
// rtl/zrb_sd_cmd_framer.sv - SD SPI-mode command framer: 0xFF fillers then 6-byte command frame
// ZRB_SD_CRC7_EN: compute the CRC7 byte; otherwise emit the fixed CMD0/CMD8/dummy value.
module zrb_sd_cmd_framer
    import zrb_sd_pkg::*;
#(
    parameter int PRE_FF = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cmd_start,
    input  logic [5:0]  cmd_index,
    input  logic [31:0] cmd_arg,
    output logic        busy,
    output logic        done,
    output logic        new_data,
    output logic [7:0]  data_out,
    input  logic        spi_full
);

    localparam logic [3:0] FILL_LAST = 4'(PRE_FF - 1);

    state_t      state, state_next;
    logic [5:0]  idx_q;
    logic [31:0] arg_q;
    logic [3:0]  fill_cnt;
    logic [2:0]  byte_idx;
    logic [7:0]  crc_byte;
    logic        accept;

    assign accept = (state == ST_IDLE) && cmd_start;

`ifdef ZRB_SD_CRC7_EN
    logic [6:0] crc_q, crc_nxt;

    zrb_crc7_byte u_crc7 (
        .crc_in  (crc_q),
        .data    (data_out),
        .crc_out (crc_nxt)
    );

    // Only header and argument bytes (0..4) are covered by the CRC.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            crc_q <= 7'd0;
        else if (accept)
            crc_q <= 7'd0;
        else if (state == ST_SEND && new_data && byte_idx != 3'd5)
            crc_q <= crc_nxt;
    end

    assign crc_byte = {crc_q, 1'b1};
`else
    assign crc_byte = fixed_crc_byte(idx_q);
`endif

    always_comb begin
        state_next = state;
        busy       = (state != ST_IDLE);
        done       = (state == ST_DONE);
        new_data   = ((state == ST_PRE) || (state == ST_SEND)) && !spi_full;
        data_out   = 8'hFF;
        case (state)
            ST_IDLE: begin
                if (cmd_start)
                    state_next = (PRE_FF != 0) ? ST_PRE : ST_SEND;
            end
            ST_PRE: begin
                if (new_data && fill_cnt == FILL_LAST)
                    state_next = ST_SEND;
            end
            ST_SEND: begin
                case (byte_idx)
                    3'd0:    data_out = {2'b01, idx_q};
                    3'd1:    data_out = arg_q[31:24];
                    3'd2:    data_out = arg_q[23:16];
                    3'd3:    data_out = arg_q[15:8];
                    3'd4:    data_out = arg_q[7:0];
                    default: data_out = crc_byte;
                endcase
                if (new_data && byte_idx == 3'd5)
                    state_next = ST_DONE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            idx_q    <= 6'd0;
            arg_q    <= 32'd0;
            fill_cnt <= 4'd0;
            byte_idx <= 3'd0;
        end else begin
            state <= state_next;
            if (accept) begin
                idx_q    <= cmd_index;
                arg_q    <= cmd_arg;
                fill_cnt <= 4'd0;
                byte_idx <= 3'd0;
            end
            if (state == ST_PRE && new_data)
                fill_cnt <= (fill_cnt == FILL_LAST) ? 4'd0 : fill_cnt + 4'd1;
            if (state == ST_SEND && new_data)
                byte_idx <= (byte_idx == 3'd5) ? 3'd0 : byte_idx + 3'd1;
        end
    end

endmodule

// File: tb/tb_zrb_sd_cmd_framer.sv
// tb/tb_zrb_sd_cmd_framer.sv - scoreboard bench for zrb_sd_cmd_framer (either ZRB_SD_CRC7_EN build)
module tb_zrb_sd_cmd_framer;

    localparam int PRE_FF = 2;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cmd_start = 1'b0;
    logic [5:0]  cmd_index = 6'd0;
    logic [31:0] cmd_arg = 32'd0;
    logic        spi_full = 1'b0;
    logic        busy, done, new_data;
    logic [7:0]  data_out;

    int total = 0;
    int bad = 0;
    int viol = 0;

    logic [7:0] exp_q[$];
    logic [7:0] rx_q[$];
    logic       hold_prev = 1'b0;
    logic [7:0] prev_data = 8'h00;

    always #5 clk = ~clk;

    zrb_sd_cmd_framer #(.PRE_FF(PRE_FF)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .cmd_start (cmd_start),
        .cmd_index (cmd_index),
        .cmd_arg   (cmd_arg),
        .busy      (busy),
        .done      (done),
        .new_data  (new_data),
        .data_out  (data_out),
        .spi_full  (spi_full)
    );

    // Monitor: capture every pushed byte; count handshake violations.
    always @(negedge clk) begin
        if (new_data)
            rx_q.push_back(data_out);
        viol      <= viol + int'(new_data && spi_full)
                          + int'(hold_prev && (data_out !== prev_data));
        hold_prev <= reset_n && busy && !done && spi_full;
        prev_data <= data_out;
    end

    function automatic logic [7:0] crc_model(input logic [5:0] idx, input logic [31:0] arg);
        logic [39:0] m;
        logic [6:0]  c;
        logic        fb;
        m = {2'b01, idx, arg};
        c = 7'd0;
        for (int i = 39; i >= 0; i--) begin
            fb = c[6] ^ m[i];
            c  = {c[5:0], 1'b0};
            if (fb)
                c = c ^ 7'h09;
        end
        return {c, 1'b1};
    endfunction

    function automatic logic [7:0] exp_last(input logic [5:0] idx, input logic [31:0] arg);
`ifdef ZRB_SD_CRC7_EN
        return crc_model(idx, arg);
`else
        if (idx == 6'd0)      return 8'h95;
        else if (idx == 6'd8) return 8'h87;
        else                  return 8'hFF;
`endif
    endfunction

    task automatic issue(input logic [5:0] idx, input logic [31:0] arg, input logic [7:0] last);
        for (int i = 0; i < PRE_FF; i++)
            exp_q.push_back(8'hFF);
        exp_q.push_back({2'b01, idx});
        exp_q.push_back(arg[31:24]);
        exp_q.push_back(arg[23:16]);
        exp_q.push_back(arg[15:8]);
        exp_q.push_back(arg[7:0]);
        exp_q.push_back(last);
        @(posedge clk); #1;
        cmd_start = 1'b1;
        cmd_index = idx;
        cmd_arg   = arg;
        @(posedge clk); #1;
        cmd_start = 1'b0;
    endtask

    // Returns the cycle (1 = cycle after accept) in which done was seen, or -1 on timeout.
    task automatic wait_done(input bit rnd_full, output int n);
        n = -1;
        for (int k = 1; k <= 400; k++) begin
            @(negedge clk);
            if (done) begin
                n = k;
                break;
            end
            @(posedge clk); #1;
            spi_full = rnd_full ? 1'($urandom_range(0, 1)) : 1'b0;
        end
        spi_full = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #12;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got %b want 0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got %b want 0", done); end
        total++; if (new_data !== 1'b0) begin bad++; $display("FAIL reset_new_data got %b want 0", new_data); end
        total++; if (data_out !== 8'hFF) begin bad++; $display("FAIL reset_data_out got %h want ff", data_out); end
        @(posedge clk); #1;
        reset_n = 1'b1;
    endtask

    task automatic test_cmd0();
        int n;
        logic [7:0] e, g;
        issue(6'd0, 32'h0, 8'h95);
        wait_done(1'b0, n);
        total++; if (n !== PRE_FF + 7) begin bad++; $display("FAIL cmd0_latency got %0d want %0d", n, PRE_FF + 7); end
        @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL cmd0_busy_after got %b want 0", busy); end
        total++; if (rx_q.size() !== exp_q.size()) begin bad++; $display("FAIL cmd0_len got %0d want %0d", rx_q.size(), exp_q.size()); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = (rx_q.size() > 0) ? rx_q.pop_front() : 8'hxx;
            total++; if (g !== e) begin bad++; $display("FAIL cmd0_byte got %h want %h", g, e); end
        end
        while (rx_q.size() > 0) void'(rx_q.pop_front());
    endtask

    task automatic test_cmd8();
        int n;
        logic [7:0] e, g;
        issue(6'd8, 32'h0000_01AA, 8'h87);
        wait_done(1'b0, n);
        total++; if (n !== PRE_FF + 7) begin bad++; $display("FAIL cmd8_latency got %0d want %0d", n, PRE_FF + 7); end
        total++; if (rx_q.size() !== exp_q.size()) begin bad++; $display("FAIL cmd8_len got %0d want %0d", rx_q.size(), exp_q.size()); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = (rx_q.size() > 0) ? rx_q.pop_front() : 8'hxx;
            total++; if (g !== e) begin bad++; $display("FAIL cmd8_byte got %h want %h", g, e); end
        end
        while (rx_q.size() > 0) void'(rx_q.pop_front());
    endtask

    task automatic test_crc_cmds();
        int n;
        logic [7:0]  e, g;
        logic [5:0]  idx_t[5];
        logic [31:0] arg_t[5];
        logic [7:0]  last_t[5];
        idx_t[0] = 6'd55; arg_t[0] = 32'h0;
        idx_t[1] = 6'd41; arg_t[1] = 32'h4000_0000;
        idx_t[2] = 6'd58; arg_t[2] = 32'h0;
        idx_t[3] = 6'd0;  arg_t[3] = 32'h0;
        idx_t[4] = 6'd17; arg_t[4] = $urandom;
`ifdef ZRB_SD_CRC7_EN
        last_t[0] = 8'h65; last_t[1] = 8'h77; last_t[2] = 8'hFD;
`else
        last_t[0] = 8'hFF; last_t[1] = 8'hFF; last_t[2] = 8'hFF;
`endif
        last_t[3] = 8'h95;
        last_t[4] = exp_last(idx_t[4], arg_t[4]);
        for (int t = 0; t < 5; t++) begin
            issue(idx_t[t], arg_t[t], last_t[t]);
            wait_done(1'b0, n);
            total++; if (n < 0) begin bad++; $display("FAIL crc_timeout cmd %0d got %0d want done", idx_t[t], n); end
            total++; if (rx_q.size() !== exp_q.size()) begin bad++; $display("FAIL crc_len cmd %0d got %0d want %0d", idx_t[t], rx_q.size(), exp_q.size()); end
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                g = (rx_q.size() > 0) ? rx_q.pop_front() : 8'hxx;
                total++; if (g !== e) begin bad++; $display("FAIL crc_byte cmd %0d got %h want %h", idx_t[t], g, e); end
            end
            while (rx_q.size() > 0) void'(rx_q.pop_front());
        end
    endtask

    task automatic test_backpressure();
        int n;
        logic [7:0] e, g;
        spi_full = 1'b1;
        issue(6'd8, 32'h0000_01AA, 8'h87);
        wait_done(1'b1, n);
        total++; if (n < 0) begin bad++; $display("FAIL bp_timeout got %0d want done", n); end
        @(negedge clk);
        total++; if (viol !== 0) begin bad++; $display("FAIL bp_handshake got %0d violations want 0", viol); end
        total++; if (rx_q.size() !== exp_q.size()) begin bad++; $display("FAIL bp_len got %0d want %0d", rx_q.size(), exp_q.size()); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = (rx_q.size() > 0) ? rx_q.pop_front() : 8'hxx;
            total++; if (g !== e) begin bad++; $display("FAIL bp_byte got %h want %h", g, e); end
        end
        while (rx_q.size() > 0) void'(rx_q.pop_front());
    endtask

    task automatic test_ignore_start();
        int n;
        logic [7:0] e, g;
        issue(6'd17, 32'h1234_5678, exp_last(6'd17, 32'h1234_5678));
        for (int k = 0; k < 50 && rx_q.size() < 3; k++)
            @(negedge clk);
        @(posedge clk); #1;
        cmd_start = 1'b1;
        cmd_index = 6'd55;
        cmd_arg   = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        cmd_start = 1'b0;
        wait_done(1'b0, n);
        total++; if (n < 0) begin bad++; $display("FAIL ign_timeout got %0d want done", n); end
        total++; if (rx_q.size() !== exp_q.size()) begin bad++; $display("FAIL ign_len got %0d want %0d", rx_q.size(), exp_q.size()); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = (rx_q.size() > 0) ? rx_q.pop_front() : 8'hxx;
            total++; if (g !== e) begin bad++; $display("FAIL ign_byte got %h want %h", g, e); end
        end
        while (rx_q.size() > 0) void'(rx_q.pop_front());
        // Start in the cycle right after done must be taken.
        issue(6'd8, 32'h0000_01AA, 8'h87);
        wait_done(1'b0, n);
        total++; if (n !== PRE_FF + 7) begin bad++; $display("FAIL b2b_latency got %0d want %0d", n, PRE_FF + 7); end
        total++; if (rx_q.size() !== exp_q.size()) begin bad++; $display("FAIL b2b_len got %0d want %0d", rx_q.size(), exp_q.size()); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = (rx_q.size() > 0) ? rx_q.pop_front() : 8'hxx;
            total++; if (g !== e) begin bad++; $display("FAIL b2b_byte got %h want %h", g, e); end
        end
        while (rx_q.size() > 0) void'(rx_q.pop_front());
    endtask

    task automatic test_reset_mid();
        int n;
        logic [7:0] e, g;
        issue(6'd8, 32'h0000_01AA, 8'h87);
        for (int k = 0; k < 50 && rx_q.size() < PRE_FF + 2; k++)
            @(negedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        total++; if (new_data !== 1'b0) begin bad++; $display("FAIL rst_mid_new_data got %b want 0", new_data); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_mid_busy got %b want 0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_mid_done got %b want 0", done); end
        @(posedge clk); #1;
        reset_n = 1'b1;
        exp_q.delete();
        while (rx_q.size() > 0) void'(rx_q.pop_front());
        issue(6'd0, 32'h0, 8'h95);
        wait_done(1'b0, n);
        total++; if (n !== PRE_FF + 7) begin bad++; $display("FAIL rst_cmd0_latency got %0d want %0d", n, PRE_FF + 7); end
        total++; if (rx_q.size() !== exp_q.size()) begin bad++; $display("FAIL rst_cmd0_len got %0d want %0d", rx_q.size(), exp_q.size()); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = (rx_q.size() > 0) ? rx_q.pop_front() : 8'hxx;
            total++; if (g !== e) begin bad++; $display("FAIL rst_cmd0_byte got %h want %h", g, e); end
        end
        while (rx_q.size() > 0) void'(rx_q.pop_front());
    endtask

    initial begin
        test_reset();
        test_cmd0();
        test_cmd8();
        test_crc_cmds();
        test_backpressure();
        test_ignore_start();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
